// File: rtl/tinyalu_cmd_issuer_if.sv
// Bundle of the command, tinyalu and response ports of tinyalu_cmd_issuer.
// slave = issuer side, master = stimulus / tinyalu / response-consumer side.
interface tinyalu_cmd_issuer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_A;
  logic [7:0]    cmd_B;
  logic [2:0]    cmd_op;
  logic          cmd_err;
  logic          alu_start;
  logic [7:0]    alu_A;
  logic [7:0]    alu_B;
  logic [2:0]    alu_op;
  logic          alu_done;
  logic [15:0]   alu_result;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_data;
  logic [2:0]    res_op;
  logic          res_err;
  logic          busy;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  cmd_valid, cmd_A, cmd_B, cmd_op, alu_done, alu_result, res_ready,
    output cmd_ready, cmd_err, alu_start, alu_A, alu_B, alu_op,
           res_valid, res_data, res_op, res_err, busy, fifo_count
  );

  modport master (
    output cmd_valid, cmd_A, cmd_B, cmd_op, alu_done, alu_result, res_ready,
    input  cmd_ready, cmd_err, alu_start, alu_A, alu_B, alu_op,
           res_valid, res_data, res_op, res_err, busy, fifo_count
  );
endinterface

// File: rtl/tinyalu_cmd_issuer.sv
// Queues ALU commands and issues them one at a time to tinyalu (start/done), returning tagged results.
// Optional issue watchdog enabled by defining TINYALU_ISSUER_TIMEOUT_EN.
module tinyalu_cmd_issuer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  tinyalu_cmd_issuer_if.slave  io_bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_NOPST, S_ISSUE, S_RESP} state_t;

  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state, w_state_nxt;
  logic          r_cmd_err;
  logic          r_alu_start;
  logic [7:0]    r_alu_A, r_alu_B;
  logic [2:0]    r_alu_op;
  logic          r_res_valid;
  logic [15:0]   r_res_data;
  logic [2:0]    r_res_op;
  logic          r_res_err;

  logic w_full, w_empty, w_legal, w_push, w_pop;
  logic w_nop_fin, w_done_fin, w_tmo_fin, w_res_ack, w_tmo_hit;
  cmd_t w_head;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_legal = (io_bus.cmd_op <= OP_MUL);
  assign w_push  = io_bus.cmd_valid & ~w_full & w_legal;
  assign w_head  = r_mem[r_rd_ptr];

`ifdef TINYALU_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Zero on the first ISSUE cycle, so a hit marks the TIMEOUT_CYCLES-th cycle without done.
  always_ff @(posedge i_clk) begin
    if (i_reset || r_state != S_ISSUE) r_tmo_cnt <= '0;
    else                               r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end

  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_nop_fin   = 1'b0;
    w_done_fin  = 1'b0;
    w_tmo_fin   = 1'b0;
    w_res_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = (w_head.op == OP_NOP) ? S_NOPST : S_ISSUE;
        end
      end
      S_NOPST: begin
        w_nop_fin   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_ISSUE: begin
        // done wins over a watchdog hit in the same cycle
        if (io_bus.alu_done) begin
          w_done_fin  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_tmo_hit) begin
          w_tmo_fin   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (io_bus.res_ready) begin
          w_res_ack   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{a: io_bus.cmd_A, b: io_bus.cmd_B, op: io_bus.cmd_op};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_err   <= 1'b0;
      r_alu_start <= 1'b0;
      r_alu_A     <= '0;
      r_alu_B     <= '0;
      r_alu_op    <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_cmd_err <= io_bus.cmd_valid & ~w_legal;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_alu_start <= 1'b1;
        r_alu_A     <= w_head.a;
        r_alu_B     <= w_head.b;
        r_alu_op    <= w_head.op;
      end
      if (w_nop_fin || w_done_fin || w_tmo_fin) begin
        r_alu_start <= 1'b0;
        r_res_valid <= 1'b1;
      end
      if (w_nop_fin) begin
        r_res_data <= '0;
        r_res_op   <= OP_NOP;
        r_res_err  <= 1'b0;
      end
      if (w_done_fin) begin
        r_res_data <= io_bus.alu_result;
        r_res_op   <= r_alu_op;
        r_res_err  <= 1'b0;
      end
      if (w_tmo_fin) begin
        r_res_data <= '0;
        r_res_op   <= r_alu_op;
        r_res_err  <= 1'b1;
      end
      if (w_res_ack) r_res_valid <= 1'b0;
    end
  end

  assign io_bus.cmd_ready  = ~w_full;
  assign io_bus.cmd_err    = r_cmd_err;
  assign io_bus.alu_start  = r_alu_start;
  assign io_bus.alu_A      = r_alu_A;
  assign io_bus.alu_B      = r_alu_B;
  assign io_bus.alu_op     = r_alu_op;
  assign io_bus.res_valid  = r_res_valid;
  assign io_bus.res_data   = r_res_data;
  assign io_bus.res_op     = r_res_op;
  assign io_bus.res_err    = r_res_err;
  assign io_bus.busy       = (r_state != S_IDLE) | ~w_empty;
  assign io_bus.fifo_count = r_count;
endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Bench for tinyalu_cmd_issuer: vector table, corner sequences and random traffic
// against an in-order response queue model, with a small tinyalu latency model.
module tb_tinyalu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tinyalu_cmd_issuer_if #(.FIFO_DEPTH(DEPTH)) bus();

  tinyalu_cmd_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai, bi;
    ai = a;
    bi = b;
    case (op)
      3'b001:  return 16'(ai + bi);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(ai * bi);
      default: return 16'h0000;
    endcase
  endfunction

  // tinyalu model: done after 1 (add/and/xor) or 3 (mul) start-high cycles
  logic alu_en = 1'b1;
  logic spur = 1'b0;
  int   lat_ovr = 0;
  int   acnt;
  int   cur_lat;
  always @(posedge clk) begin
    if (reset || !bus.alu_start) acnt <= 0;
    else                         acnt <= acnt + 1;
  end
  assign cur_lat = (lat_ovr > 0) ? lat_ovr : ((bus.alu_op == 3'b100) ? 3 : 1);
  assign bus.alu_done = bus.alu_start ? (alu_en && bus.alu_op != 3'b000 && acnt == cur_lat) : spur;
  assign bus.alu_result = bus.alu_start ? alu_ref(bus.alu_op, bus.alu_A, bus.alu_B) : 16'hDEAD;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic        err;
  } rsp_t;
  rsp_t expq[$];
  logic hang = 1'b0;
  logic exp_cerr = 1'b0;
  logic prev_start = 1'b0;
  logic [18:0] prev_ops = '0;

  always @(negedge clk) begin
    rsp_t r;
    if (reset) begin
      expq.delete();
      exp_cerr   <= 1'b0;
      prev_start <= 1'b0;
    end else begin
      chk("cmd_err_pulse", bus.cmd_err, exp_cerr);
      exp_cerr <= bus.cmd_valid && (bus.cmd_op > 3'b100);
      if (bus.alu_start && prev_start) chk("alu_hold", {bus.alu_A, bus.alu_B, bus.alu_op}, prev_ops);
      prev_start <= bus.alu_start;
      prev_ops   <= {bus.alu_A, bus.alu_B, bus.alu_op};
      if (bus.res_valid && bus.res_ready) begin
        if (expq.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          r = expq.pop_front();
          chk("sb_res_data", bus.res_data, r.data);
          chk("sb_res_op", bus.res_op, r.op);
          chk("sb_res_err", bus.res_err, r.err);
        end
      end
      if (bus.cmd_valid && bus.cmd_ready && bus.cmd_op <= 3'b100) begin
        r.op   = bus.cmd_op;
        r.data = alu_ref(bus.cmd_op, bus.cmd_A, bus.cmd_B);
        r.err  = 1'b0;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
        if (hang && bus.cmd_op != 3'b000) begin
          r.data = 16'h0000;
          r.err  = 1'b1;
        end
`endif
        expq.push_back(r);
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_data;
    logic        exp_cerr;
    int          exp_burst;
  } vec_t;
  vec_t vt[10];

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_A     = a;
    bus.cmd_B     = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0] = '{3'b001, 8'hFF, 8'h01, 16'h0100, 1'b0, 2};
    vt[1] = '{3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 4};
    vt[2] = '{3'b000, 8'h12, 8'h34, 16'h0000, 1'b0, 1};
    vt[3] = '{3'b011, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 2};
    vt[4] = '{3'b010, 8'hAA, 8'h0F, 16'h000A, 1'b0, 2};
    vt[5] = '{3'b110, 8'h01, 8'h02, 16'h0000, 1'b1, 0};
    vt[6] = '{3'b100, 8'h10, 8'h10, 16'h0100, 1'b0, 4};
    vt[7] = '{3'b111, 8'h33, 8'h44, 16'h0000, 1'b1, 0};
    vt[8] = '{3'b101, 8'h55, 8'h66, 16'h0000, 1'b1, 0};
    vt[9] = '{3'b001, 8'h80, 8'h80, 16'h0100, 1'b0, 2};

    bus.cmd_valid = 1'b0;
    bus.cmd_A = '0;
    bus.cmd_B = '0;
    bus.cmd_op = '0;
    bus.res_ready = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_outputs", {bus.cmd_err, bus.alu_start, bus.alu_A, bus.alu_B, bus.alu_op,
                        bus.res_valid, bus.res_data, bus.res_op, bus.res_err, bus.busy, bus.fifo_count}, 0);
    reset = 1'b0;
    step();

    // vector table, one command at a time
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b);
      step();
      bus.cmd_valid = 1'b0;
      if (vt[i].exp_cerr) begin
        chk("tv_cmd_err", bus.cmd_err, 1);
        chk("tv_err_count", bus.fifo_count, 0);
        step();
        chk("tv_err_pulse_end", bus.cmd_err, 0);
        chk("tv_err_no_start", {bus.alu_start, bus.busy}, 0);
      end else begin
        chk("tv_count", bus.fifo_count, 1);
        chk("tv_start_early", bus.alu_start, 0);
        step();
        chk("tv_start_lat", bus.alu_start, 1);
        chk("tv_alu_op", {bus.alu_op, bus.alu_A, bus.alu_B}, {vt[i].op, vt[i].a, vt[i].b});
        n = 0;
        while (bus.alu_start && n < 50) begin n++; step(); end
        chk("tv_burst", n, vt[i].exp_burst);
        chk("tv_res_valid", bus.res_valid, 1);
        chk("tv_res_data", bus.res_data, vt[i].exp_data);
        chk("tv_res_op", bus.res_op, vt[i].op);
        chk("tv_res_err", bus.res_err, 0);
        step();
        chk("tv_res_drop", {bus.res_valid, bus.alu_start, bus.busy}, 0);
      end
    end

    // fill the queue while the response is held
    bus.res_ready = 1'b0;
    drive(3'b001, 8'h01, 8'h02); step();
    drive(3'b100, 8'h03, 8'h04); step();
    drive(3'b011, 8'h55, 8'hAA); step();
    drive(3'b000, 8'h00, 8'h00); step();
    drive(3'b010, 8'hF0, 8'hFF); step();
    chk("fill_count", bus.fifo_count, 4);
    chk("fill_ready", bus.cmd_ready, 0);
    drive(3'b011, 8'h0F, 8'h0F); step();
    chk("full_no_push", bus.fifo_count, 4);
    chk("hold_res", {bus.res_valid, bus.res_op, bus.res_data}, {1'b1, 3'b001, 16'h0003});
    drive(3'b111, 8'h00, 8'h00); step();
    chk("full_cmd_err", bus.cmd_err, 1);
    chk("full_err_count", bus.fifo_count, 4);
    drive(3'b010, 8'h33, 8'h0F);
    bus.res_ready = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin n++; step(); end
    chk("full_pop_count", bus.fifo_count, 3);
    step();
    bus.cmd_valid = 1'b0;
    n = 0;
    while ((expq.size() != 0 || bus.busy) && n < 200) begin n++; step(); end
    chk("fill_drain", expq.size(), 0);

    // done only at the 16th start-high cycle still completes normally
    lat_ovr = 15;
    drive(3'b001, 8'h22, 8'h11); step();
    bus.cmd_valid = 1'b0;
    step();
    n = 0;
    while (bus.alu_start && n < 60) begin n++; step(); end
    chk("late_burst", n, 16);
    chk("late_res", {bus.res_valid, bus.res_err, bus.res_data}, {1'b1, 1'b0, 16'h0033});
    step();
    lat_ovr = 0;

    // reset while a command is in ISSUE with more queued
    alu_en = 1'b0;
    hang = 1'b1;
    drive(3'b100, 8'h07, 8'h07); step();
    drive(3'b001, 8'h01, 8'h01); step();
    drive(3'b011, 8'h02, 8'h03); step();
    bus.cmd_valid = 1'b0;
    step();
    chk("pre_rst_state", {bus.alu_start, bus.fifo_count}, {1'b1, 3'd2});
    reset = 1'b1;
    step();
    chk("mid_rst_ready", bus.cmd_ready, 1);
    chk("mid_rst_outputs", {bus.cmd_err, bus.alu_start, bus.alu_A, bus.alu_B, bus.alu_op,
                            bus.res_valid, bus.res_data, bus.res_op, bus.res_err, bus.busy, bus.fifo_count}, 0);
    reset = 1'b0;
    step();

    // done never comes
    drive(3'b100, 8'h07, 8'h07); step();
    bus.cmd_valid = 1'b0;
    hang = 1'b0;
    step();
    n = 0;
    while (bus.alu_start && n < 60) begin n++; step(); end
`ifdef TINYALU_ISSUER_TIMEOUT_EN
    chk("tmo_burst", n, TMO);
    chk("tmo_res", {bus.res_valid, bus.res_err, bus.res_op, bus.res_data}, {1'b1, 1'b1, 3'b100, 16'h0000});
    step();
`else
    chk("no_tmo_wait", n, 60);
    chk("no_tmo_res", bus.res_valid, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif
    alu_en = 1'b1;
    step();
    chk("post_hang_idle", {bus.busy, bus.res_valid, bus.alu_start}, 0);

    // random traffic with spurious done outside ISSUE
    for (int c = 0; c < 400; c++) begin
      bus.cmd_valid = ($urandom_range(0, 1) == 1);
      bus.cmd_op    = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      bus.cmd_A     = 8'($urandom);
      bus.cmd_B     = 8'($urandom);
      bus.res_ready = ($urandom_range(0, 9) < 7);
      spur          = ($urandom_range(0, 9) == 0);
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    spur = 1'b0;
    n = 0;
    while ((expq.size() != 0 || bus.busy) && n < 300) begin n++; step(); end
    chk("rand_drain", expq.size(), 0);
    chk("rand_idle", {bus.busy, bus.alu_start, bus.fifo_count}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
